phinc_ctrl: RTL



---
 rtl/phinc_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/phinc_ctrl.sv
// phinc_ctrl: front-panel button conditioning (sync, debounce, auto-repeat) driving a saturating phase increment.
// Latency: phinc/step update DEB_CYC+3 cycles after a clean press is first sampled; repeats follow RPT_DELAY then every RPT_RATE.
// Backpressure: none; buttons are level inputs and every output is a free-running register.
module phinc_ctrl #(
   parameter int W         = 8,
   parameter int DEFAULT   = 1,
   parameter int MIN       = 1,
   parameter int MAX       = 255,
   parameter int DEB_CYC   = 50000,
   parameter int RPT_DELAY = 12500000,
   parameter int RPT_RATE  = 2500000
) (
   input  logic         clk,
   input  logic         clrn,
   input  logic         phase_up,
   input  logic         phase_dn,
   output logic [W-1:0] phinc,
   output logic         step,
   output logic         at_min,
   output logic         at_max
);

   localparam int DBW     = $clog2(DEB_CYC);
   localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int RCW     = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

   localparam logic [DBW-1:0] DEB_LAST = DBW'(DEB_CYC - 1);
   localparam logic [RCW-1:0] RC_DELAY = RCW'(RPT_DELAY - 1);
   localparam logic [RCW-1:0] RC_RATE  = RCW'(RPT_RATE - 1);
   localparam logic [W-1:0]   DEF_V    = W'(DEFAULT);
   localparam logic [W-1:0]   MIN_V    = W'(MIN);
   localparam logic [W-1:0]   MAX_V    = W'(MAX);
   localparam logic [W-1:0]   ONE_V    = W'(1);

   typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, LOCK} state_t;

   // Index 0 is the up button, index 1 the down button; 1 means released.
   logic [1:0]          sync1_q, sync2_q;
   logic [1:0]          db_q, db_d;
   logic [1:0][DBW-1:0] dcnt_q, dcnt_d;

   state_t              state_q, state_d;
   logic [RCW-1:0]      rc_q, rc_d;
   logic                req_up_q, req_up_d;
   logic                req_dn_q, req_dn_d;

   logic [W-1:0]        phinc_q, phinc_d;
   logic                step_q, step_d;
   logic                at_min_q, at_max_q;

   logic                up_p, dn_p;

   assign up_p = ~db_q[0];
   assign dn_p = ~db_q[1];

   // Two-flop synchronisers for the asynchronous raw buttons, reset to released.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= {phase_dn, phase_up};
         sync2_q <= sync1_q;
      end
   end

   // Debounce: count consecutive samples that disagree with the accepted state; flip after DEB_CYC of them.
   always_comb begin
      db_d   = db_q;
      dcnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != db_q[i]) begin
            if (dcnt_q[i] == DEB_LAST) begin
               db_d[i] = ~db_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + DBW'(1);
            end
         end
      end
   end

   // Debounced state and counters.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         db_q   <= 2'b11;
         dcnt_q <= '0;
      end else begin
         db_q   <= db_d;
         dcnt_q <= dcnt_d;
      end
   end

   // Press/hold/lock decisions; a step request is registered and applied to phinc one cycle later.
   always_comb begin
      state_d  = state_q;
      rc_d     = rc_q;
      req_up_d = 1'b0;
      req_dn_d = 1'b0;
      case (state_q)
         IDLE: begin
            rc_d = '0;
            if (up_p && dn_p) begin
               state_d = LOCK;
            end else if (up_p) begin
               req_up_d = 1'b1;
               rc_d     = RC_DELAY;
               state_d  = HOLD_UP;
            end else if (dn_p) begin
               req_dn_d = 1'b1;
               rc_d     = RC_DELAY;
               state_d  = HOLD_DN;
            end
         end
         HOLD_UP: begin
            if (dn_p) begin
               state_d = LOCK;
            end else if (!up_p) begin
               state_d = IDLE;
            end else if (rc_q == '0) begin
               req_up_d = 1'b1;
               rc_d     = RC_RATE;
            end else begin
               rc_d = rc_q - RCW'(1);
            end
         end
         HOLD_DN: begin
            if (up_p) begin
               state_d = LOCK;
            end else if (!dn_p) begin
               state_d = IDLE;
            end else if (rc_q == '0) begin
               req_dn_d = 1'b1;
               rc_d     = RC_RATE;
            end else begin
               rc_d = rc_q - RCW'(1);
            end
         end
         LOCK: begin
            rc_d = '0;
            if (!up_p && !dn_p) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            rc_d    = '0;
         end
      endcase
   end

   // FSM state, repeat counter and pending step requests.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= IDLE;
         rc_q     <= '0;
         req_up_q <= 1'b0;
         req_dn_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rc_q     <= rc_d;
         req_up_q <= req_up_d;
         req_dn_q <= req_dn_d;
      end
   end

   // Saturating step: a request at a limit is dropped without a step pulse.
   always_comb begin
      phinc_d = phinc_q;
      step_d  = 1'b0;
      if (req_up_q && (phinc_q != MAX_V)) begin
         phinc_d = phinc_q + ONE_V;
         step_d  = 1'b1;
      end else if (req_dn_q && (phinc_q != MIN_V)) begin
         phinc_d = phinc_q - ONE_V;
         step_d  = 1'b1;
      end
   end

   // Output registers; flags derive from the next value so they always match phinc.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         phinc_q  <= DEF_V;
         step_q   <= 1'b0;
         at_min_q <= (DEF_V == MIN_V);
         at_max_q <= (DEF_V == MAX_V);
      end else begin
         phinc_q  <= phinc_d;
         step_q   <= step_d;
         at_min_q <= (phinc_d == MIN_V);
         at_max_q <= (phinc_d == MAX_V);
      end
   end

   assign phinc  = phinc_q;
   assign step   = step_q;
   assign at_min = at_min_q;
   assign at_max = at_max_q;

endmodule
